// File: rtl/evp_pkg.sv
// Shared definitions for the Horner polynomial-evaluation controller.
//   - clog2: constant-width helper used to size the address buses
//   - evp_state_e: controller state encoding
//   - Status*: codes reported on the status output
package evp_pkg;

    function automatic int unsigned clog2(input int unsigned value);
        int unsigned r;
        r = 0;
        for (int i = 0; i < 32; i++) begin
            if ((32'd1 << i) < value) begin
                r = i + 1;
            end
        end
        return r;
    endfunction

    typedef enum logic [3:0] {
        StIdle,
        StRdN,
        StChkN,
        StRdX,
        StLoad,
        StFetch,
        StMac,
        StEmit,
        StErr,
        StDone
    } evp_state_e;

    localparam logic [31:0] StatusOk        = 32'd0;
    localparam logic [31:0] StatusOvf       = 32'd1;
    localparam logic [31:0] StatusUndefN    = 32'd2;
    localparam logic [31:0] StatusDegTooBig = 32'd3;
    localparam logic [31:0] StatusZeroCount = 32'd4;
    localparam logic [31:0] StatusReset     = 32'hFFFF_FFFF;

endpackage

// File: rtl/evp_horner_fsm_if.sv
// Bundle between the command decoder / RAMs (master) and the Horner controller (slave).
//   command : start_evp, A, x_count, rd_addr_data
//   RAM data: ram_out_data, ram_out_S, N
//   RAM ctrl: en_rd_data, en_rd_S, en_rd_N, rd_addr_data_updated, rd_addr_S_vec,
//             rd_addr_S_coef, rd_addr_N
//   results : busy, result_valid, result, status, done_evp
interface evp_horner_fsm_if #(
    parameter int unsigned BUF_DEPTH = 1024,
    parameter int unsigned DATA_W    = 16,
    parameter int unsigned ACC_W     = 32,
    parameter int unsigned NUM_VEC   = 8,
    parameter int unsigned DEG_W     = 5,
    parameter int unsigned MAX_DEG   = 10,
    parameter int unsigned CNT_W     = 8
);
    import evp_pkg::*;

    localparam int unsigned BUF_AW  = clog2(BUF_DEPTH);
    localparam int unsigned VEC_AW  = clog2(NUM_VEC);
    localparam int unsigned COEF_AW = clog2(MAX_DEG + 1);

    logic                start_evp;
    logic [VEC_AW-1:0]   A;
    logic [CNT_W-1:0]    x_count;
    logic [BUF_AW-1:0]   rd_addr_data;
    logic [DATA_W-1:0]   ram_out_data;
    logic [DATA_W-1:0]   ram_out_S;
    logic [DEG_W-1:0]    N;

    logic                en_rd_data;
    logic                en_rd_S;
    logic                en_rd_N;
    logic [BUF_AW-1:0]   rd_addr_data_updated;
    logic [VEC_AW-1:0]   rd_addr_S_vec;
    logic [COEF_AW-1:0]  rd_addr_S_coef;
    logic [VEC_AW-1:0]   rd_addr_N;
    logic                busy;
    logic                result_valid;
    logic [ACC_W-1:0]    result;
    logic [31:0]         status;
    logic                done_evp;

    modport master (
        output start_evp, A, x_count, rd_addr_data, ram_out_data, ram_out_S, N,
        input  en_rd_data, en_rd_S, en_rd_N, rd_addr_data_updated, rd_addr_S_vec,
               rd_addr_S_coef, rd_addr_N, busy, result_valid, result, status, done_evp
    );

    modport slave (
        input  start_evp, A, x_count, rd_addr_data, ram_out_data, ram_out_S, N,
        output en_rd_data, en_rd_S, en_rd_N, rd_addr_data_updated, rd_addr_S_vec,
               rd_addr_S_coef, rd_addr_N, busy, result_valid, result, status, done_evp
    );

endinterface

// File: rtl/evp_horner_mac.sv
// One Horner step: next_acc = acc * x + c, computed at full width.
//   acc, x, c : current accumulator, sample, coefficient
//   next_acc  : low ACC_W bits of the exact value
//   ovf       : exact value did not fit in ACC_W bits
module evp_horner_mac #(
    parameter int unsigned ACC_W  = 32,
    parameter int unsigned DATA_W = 16
) (
    input  logic [ACC_W-1:0]  acc,
    input  logic [DATA_W-1:0] x,
    input  logic [DATA_W-1:0] c,
    output logic [ACC_W-1:0]  next_acc,
    output logic              ovf
);
    // One extra bit so the carry from adding c can never be lost.
    localparam int unsigned FULL_W = ACC_W + DATA_W + 1;

    logic [FULL_W-1:0] full;

    assign full     = FULL_W'(acc) * FULL_W'(x) + FULL_W'(c);
    assign next_acc = full[ACC_W-1:0];
    assign ovf      = |full[FULL_W-1:ACC_W];

endmodule

// File: rtl/evp_horner_fsm.sv
// Batch polynomial evaluator: for x_count consecutive buffer samples starting at
// rd_addr_data, computes sum(c_i * x^i) by Horner's method using coefficient
// vector A (degree read from the N RAM, coefficients from the S RAM).
//   clk, rst : clock, asynchronous active-low reset
//   bus      : slave side of evp_horner_fsm_if (command, RAM ports, results)
module evp_horner_fsm
    import evp_pkg::*;
#(
    parameter int unsigned BUF_DEPTH = 1024,
    parameter int unsigned DATA_W    = 16,
    parameter int unsigned ACC_W     = 32,
    parameter int unsigned NUM_VEC   = 8,
    parameter int unsigned DEG_W     = 5,
    parameter int unsigned MAX_DEG   = 10,
    parameter int unsigned CNT_W     = 8
) (
    input logic             clk,
    input logic             rst,
    evp_horner_fsm_if.slave bus
);
    localparam int unsigned BUF_AW  = clog2(BUF_DEPTH);
    localparam int unsigned VEC_AW  = clog2(NUM_VEC);
    localparam int unsigned COEF_AW = clog2(MAX_DEG + 1);

    localparam logic [DEG_W-1:0] N_UNDEF = '1;
    localparam logic [DEG_W-1:0] N_MAX   = DEG_W'(MAX_DEG);

    evp_state_e          state_q;
    logic [BUF_AW-1:0]   ptr_q;
    logic [VEC_AW-1:0]   vec_q;
    logic [COEF_AW-1:0]  coef_q;
    logic [CNT_W-1:0]    cnt_q;
    logic [DEG_W-1:0]    n_q;
    logic [DATA_W-1:0]   x_q;
    logic [ACC_W-1:0]    acc_q;
    logic                ovf_q;
    logic [31:0]         err_q;
    logic                busy_q;
    logic                valid_q;
    logic [ACC_W-1:0]    result_q;
    logic [31:0]         status_q;
    logic                done_q;

    logic [ACC_W-1:0]    next_acc;
    logic                mac_ovf;

    evp_horner_mac #(
        .ACC_W  (ACC_W),
        .DATA_W (DATA_W)
    ) u_mac (
        .acc      (acc_q),
        .x        (x_q),
        .c        (bus.ram_out_S),
        .next_acc (next_acc),
        .ovf      (mac_ovf)
    );

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state_q  <= StIdle;
            ptr_q    <= '0;
            vec_q    <= '0;
            coef_q   <= '0;
            cnt_q    <= '0;
            n_q      <= '0;
            x_q      <= '0;
            acc_q    <= '0;
            ovf_q    <= 1'b0;
            err_q    <= StatusOk;
            busy_q   <= 1'b0;
            valid_q  <= 1'b0;
            result_q <= '0;
            status_q <= StatusReset;
            done_q   <= 1'b0;
        end else begin
            valid_q <= 1'b0;
            done_q  <= 1'b0;
            unique case (state_q)
                StIdle: begin
                    if (bus.start_evp) begin
                        vec_q   <= bus.A;
                        cnt_q   <= bus.x_count;
                        ptr_q   <= bus.rd_addr_data;
                        busy_q  <= 1'b1;
                        state_q <= StRdN;
                    end
                end
                StRdN: state_q <= StChkN;
                StChkN: begin
                    // N is only valid this cycle, so keep a copy for later samples.
                    n_q    <= bus.N;
                    coef_q <= COEF_AW'(bus.N);
                    if (bus.N == N_UNDEF) begin
                        err_q   <= StatusUndefN;
                        state_q <= StErr;
                    end else if (bus.N > N_MAX) begin
                        err_q   <= StatusDegTooBig;
                        state_q <= StErr;
                    end else if (cnt_q == '0) begin
                        err_q   <= StatusZeroCount;
                        state_q <= StErr;
                    end else begin
                        state_q <= StRdX;
                    end
                end
                StRdX: state_q <= StLoad;
                StLoad: begin
                    x_q   <= bus.ram_out_data;
                    acc_q <= bus.ram_out_S;
                    ovf_q <= 1'b0;
                    if (n_q == '0) begin
                        state_q <= StEmit;
                    end else begin
                        coef_q  <= coef_q - COEF_AW'(1);
                        state_q <= StFetch;
                    end
                end
                StFetch: state_q <= StMac;
                StMac: begin
                    acc_q <= next_acc;
                    ovf_q <= ovf_q | mac_ovf;
                    if (coef_q == '0) begin
                        state_q <= StEmit;
                    end else begin
                        coef_q  <= coef_q - COEF_AW'(1);
                        state_q <= StFetch;
                    end
                end
                StEmit: begin
                    result_q <= acc_q;
                    status_q <= ovf_q ? StatusOvf : StatusOk;
                    valid_q  <= 1'b1;
                    // Power-of-two depth: the natural wrap of ptr_q is the modulo.
                    ptr_q    <= ptr_q + BUF_AW'(1);
                    cnt_q    <= cnt_q - CNT_W'(1);
                    coef_q   <= COEF_AW'(n_q);
                    state_q  <= (cnt_q != CNT_W'(1)) ? StRdX : StDone;
                end
                StErr: begin
                    result_q <= '0;
                    status_q <= err_q;
                    valid_q  <= 1'b1;
                    state_q  <= StDone;
                end
                StDone: begin
                    done_q  <= 1'b1;
                    busy_q  <= 1'b0;
                    state_q <= StIdle;
                end
                default: state_q <= StIdle;
            endcase
        end
    end

    assign bus.en_rd_N              = (state_q == StRdN);
    assign bus.en_rd_data           = (state_q == StRdX);
    assign bus.en_rd_S              = (state_q == StRdX) || (state_q == StFetch);
    assign bus.rd_addr_data_updated = ptr_q;
    assign bus.rd_addr_S_vec        = vec_q;
    assign bus.rd_addr_S_coef       = coef_q;
    assign bus.rd_addr_N            = vec_q;
    assign bus.busy                 = busy_q;
    assign bus.result_valid         = valid_q;
    assign bus.result               = result_q;
    assign bus.status               = status_q;
    assign bus.done_evp             = done_q;

endmodule

// File: tb/tb_evp_horner_fsm.sv
// Directed bench for evp_horner_fsm with behavioural synchronous RAM models.
module tb_evp_horner_fsm;
    import evp_pkg::*;

    localparam int unsigned BUF_DEPTH = 1024;
    localparam int unsigned DATA_W    = 16;
    localparam int unsigned ACC_W     = 32;
    localparam int unsigned NUM_VEC   = 8;
    localparam int unsigned DEG_W     = 5;
    localparam int unsigned MAX_DEG   = 10;
    localparam int unsigned CNT_W     = 8;
    localparam int unsigned BUF_AW    = clog2(BUF_DEPTH);
    localparam int unsigned VEC_AW    = clog2(NUM_VEC);

    logic clk = 1'b0;
    logic rst = 1'b0;
    always #5 clk = ~clk;

    evp_horner_fsm_if #(
        .BUF_DEPTH (BUF_DEPTH), .DATA_W (DATA_W), .ACC_W (ACC_W), .NUM_VEC (NUM_VEC),
        .DEG_W (DEG_W), .MAX_DEG (MAX_DEG), .CNT_W (CNT_W)
    ) bus ();

    evp_horner_fsm #(
        .BUF_DEPTH (BUF_DEPTH), .DATA_W (DATA_W), .ACC_W (ACC_W), .NUM_VEC (NUM_VEC),
        .DEG_W (DEG_W), .MAX_DEG (MAX_DEG), .CNT_W (CNT_W)
    ) dut (
        .clk (clk),
        .rst (rst),
        .bus (bus)
    );

    logic [DATA_W-1:0] d_mem [BUF_DEPTH];
    logic [DATA_W-1:0] s_mem [NUM_VEC][MAX_DEG+1];
    logic [DEG_W-1:0]  n_mem [NUM_VEC];

    int          data_rd_cnt = 0;
    int unsigned data_log[$];
    int          n_checks = 0;
    int          n_fails  = 0;

    always @(posedge clk) begin
        if (bus.en_rd_data) begin
            bus.ram_out_data <= d_mem[bus.rd_addr_data_updated];
            data_log.push_back(32'(bus.rd_addr_data_updated));
            data_rd_cnt <= data_rd_cnt + 1;
        end
        if (bus.en_rd_S) bus.ram_out_S <= s_mem[bus.rd_addr_S_vec][bus.rd_addr_S_coef];
        if (bus.en_rd_N) bus.N <= n_mem[bus.rd_addr_N];
    end

    task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        n_checks++;
        assert (obs === exp) else begin
            n_fails++;
            $error("FAIL %s: observed 0x%0h expected 0x%0h", tag, obs, exp);
        end
    endtask

    task automatic start_cmd(input int a, input int cnt, input int addr);
        @(negedge clk);
        bus.A            = VEC_AW'(a);
        bus.x_count      = CNT_W'(cnt);
        bus.rd_addr_data = BUF_AW'(addr);
        bus.start_evp    = 1'b1;
        @(posedge clk);
        #1 bus.start_evp = 1'b0;
    endtask

    // Cycles are counted from the sampling edge of start_evp (or the previous hit).
    task automatic wait_valid(output int cyc);
        cyc = -1;
        for (int i = 1; i <= 200; i++) begin
            @(negedge clk);
            if (bus.result_valid) begin
                cyc = i;
                break;
            end
        end
    endtask

    initial begin
        #2_000_000;
        $display("FAIL global_timeout: simulation did not finish");
        $fatal(1, "timeout");
    end

    initial begin
        int cyc;
        int rd_before;
        int vcount;

        for (int i = 0; i < int'(BUF_DEPTH); i++) d_mem[i] = '0;
        for (int v = 0; v < int'(NUM_VEC); v++) begin
            n_mem[v] = '0;
            for (int c = 0; c <= int'(MAX_DEG); c++) s_mem[v][c] = '0;
        end
        bus.start_evp = 1'b0; bus.A = '0; bus.x_count = '0; bus.rd_addr_data = '0;
        bus.ram_out_data = '0; bus.ram_out_S = '0; bus.N = '0;

        // Vector 2: degree 2, c0..c2 = 3,2,1
        n_mem[2] = 5'd2; s_mem[2][0] = 16'd3; s_mem[2][1] = 16'd2; s_mem[2][2] = 16'd1;
        n_mem[3] = 5'b11111;
        n_mem[4] = 5'd12;
        n_mem[5] = 5'd3;
        for (int c = 0; c <= 3; c++) s_mem[5][c] = 16'hFFFF;
        d_mem[100] = 16'd5;
        d_mem[200] = 16'd0; d_mem[201] = 16'd1; d_mem[202] = 16'd2;
        d_mem[300] = 16'hFFFF;
        d_mem[1023] = 16'd1; d_mem[0] = 16'd2;

        // Reset state
        repeat (3) @(negedge clk);
        chk("rst_busy", 64'(bus.busy), 64'd0);
        chk("rst_result", 64'(bus.result), 64'd0);
        chk("rst_status", 64'(bus.status), 64'hFFFF_FFFF);
        chk("rst_valid", 64'(bus.result_valid), 64'd0);
        chk("rst_done", 64'(bus.done_evp), 64'd0);
        chk("rst_ptr", 64'(bus.rd_addr_data_updated), 64'd0);
        rst = 1'b1;

        // Single sample x=5 -> 3 + 2*5 + 25 = 38
        start_cmd(2, 1, 100);
        wait_valid(cyc);
        chk("s1_latency", 64'(cyc), 64'd10);
        chk("s1_result", 64'(bus.result), 64'd38);
        chk("s1_status", 64'(bus.status), 64'd0);
        @(negedge clk);
        chk("s1_done", 64'(bus.done_evp), 64'd1);
        chk("s1_valid_pulse", 64'(bus.result_valid), 64'd0);
        chk("s1_busy_off", 64'(bus.busy), 64'd0);

        // Batch of three: x = 0,1,2 -> 3, 6, 11
        start_cmd(2, 3, 200);
        wait_valid(cyc);
        chk("b_lat0", 64'(cyc), 64'd10);
        chk("b_res0", 64'(bus.result), 64'd3);
        wait_valid(cyc);
        chk("b_lat1", 64'(cyc), 64'd7);
        chk("b_res1", 64'(bus.result), 64'd6);
        wait_valid(cyc);
        chk("b_lat2", 64'(cyc), 64'd7);
        chk("b_res2", 64'(bus.result), 64'd11);
        @(negedge clk);
        chk("b_done", 64'(bus.done_evp), 64'd1);
        chk("b_ptr", 64'(bus.rd_addr_data_updated), 64'd203);

        // Error paths
        rd_before = data_rd_cnt;
        start_cmd(3, 1, 100);
        wait_valid(cyc);
        chk("eu_latency", 64'(cyc), 64'd4);
        chk("eu_result", 64'(bus.result), 64'd0);
        chk("eu_status", 64'(bus.status), 64'd2);
        @(negedge clk);
        chk("eu_done", 64'(bus.done_evp), 64'd1);
        chk("eu_no_data_rd", 64'(data_rd_cnt - rd_before), 64'd0);

        start_cmd(4, 1, 100);
        wait_valid(cyc);
        chk("ed_latency", 64'(cyc), 64'd4);
        chk("ed_status", 64'(bus.status), 64'd3);
        @(negedge clk);
        chk("ed_done", 64'(bus.done_evp), 64'd1);

        start_cmd(2, 0, 100);
        wait_valid(cyc);
        chk("ez_latency", 64'(cyc), 64'd4);
        chk("ez_status", 64'(bus.status), 64'd4);
        chk("ez_result", 64'(bus.result), 64'd0);
        @(negedge clk);
        chk("ez_done", 64'(bus.done_evp), 64'd1);
        chk("e_no_data_rd", 64'(data_rd_cnt - rd_before), 64'd0);

        // Overflow: N=3, all 0xFFFF -> low 32 bits of exact value = 0xFFFE0000
        start_cmd(5, 1, 300);
        wait_valid(cyc);
        chk("ov_latency", 64'(cyc), 64'd12);
        chk("ov_status", 64'(bus.status), 64'd1);
        chk("ov_result", 64'(bus.result), 64'hFFFE_0000);

        // Buffer wrap: 1023 then 0 -> results 6, 11
        @(negedge clk);
        data_log.delete();
        start_cmd(2, 2, 1023);
        wait_valid(cyc);
        chk("w_res0", 64'(bus.result), 64'd6);
        chk("w_status0", 64'(bus.status), 64'd0);
        wait_valid(cyc);
        chk("w_res1", 64'(bus.result), 64'd11);
        @(negedge clk);
        chk("w_done", 64'(bus.done_evp), 64'd1);
        chk("w_ptr", 64'(bus.rd_addr_data_updated), 64'd1);
        chk("w_nreads", 64'(data_log.size()), 64'd2);
        if (data_log.size() == 2) begin
            chk("w_addr0", 64'(data_log[0]), 64'd1023);
            chk("w_addr1", 64'(data_log[1]), 64'd0);
        end

        // Reset during MAC of the second sample
        start_cmd(2, 2, 200);
        wait_valid(cyc);
        chk("r_res0", 64'(bus.result), 64'd3);
        repeat (3) @(negedge clk);
        #2 rst = 1'b0;
        #1;
        chk("r_busy", 64'(bus.busy), 64'd0);
        chk("r_result", 64'(bus.result), 64'd0);
        chk("r_status", 64'(bus.status), 64'hFFFF_FFFF);
        chk("r_valid", 64'(bus.result_valid), 64'd0);
        chk("r_ptr", 64'(bus.rd_addr_data_updated), 64'd0);
        chk("r_coef", 64'(bus.rd_addr_S_coef), 64'd0);
        chk("r_en_s", 64'(bus.en_rd_S), 64'd0);
        repeat (2) @(negedge clk);
        rst = 1'b1;
        vcount = 0;
        for (int i = 0; i < 10; i++) begin
            @(negedge clk);
            if (bus.result_valid || bus.done_evp) vcount++;
        end
        chk("r_no_partial", 64'(vcount), 64'd0);

        start_cmd(2, 1, 100);
        wait_valid(cyc);
        chk("r2_latency", 64'(cyc), 64'd10);
        chk("r2_result", 64'(bus.result), 64'd38);
        chk("r2_status", 64'(bus.status), 64'd0);
        @(negedge clk);
        chk("r2_done", 64'(bus.done_evp), 64'd1);

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fails);
        $finish;
    end

endmodule

// File: doc/evp_horner_fsm.md
# evp_horner_fsm

Parametrised successor to the single-sample polynomial-evaluation controller. Evaluates P(x) = Σ c_i·x^i by Horner's method for a batch of consecutive x samples from the data buffer. N is read once from the N RAM and coefficients from the S RAM. It adds configurable widths and depths, batch evaluation, buffer-address wrap-around, overflow detection and per-sample result handshaking. Sits between the top-level command decoder and the data, S and N RAMs.

## Interface
Parameters:
- BUF_DEPTH, 1024, data-buffer depth; power of two; BUF_AW = clog2(BUF_DEPTH)
- DATA_W, 16, width of x and coefficients (unsigned)
- ACC_W, 32, accumulator and result width
- NUM_VEC, 8, number of coefficient vectors; VEC_AW = clog2(NUM_VEC)
- DEG_W, 5, width of N; N = all-ones marks an undefined vector
- MAX_DEG, 10, largest legal degree; COEF_AW = clog2(MAX_DEG+1)
- CNT_W, 8, width of the batch count

Ports:
- clk  in  1  clock
- rst  in  1  asynchronous, active-low reset
- start_evp  in  1  command strobe; sampled only in IDLE
- A  in  VEC_AW  coefficient-vector select
- x_count  in  CNT_W  number of consecutive x samples to evaluate
- rd_addr_data  in  BUF_AW  address of the first x
- ram_out_data  in  DATA_W  data-RAM read data
- ram_out_S  in  DATA_W  S-RAM read data
- N  in  DEG_W  N-RAM read data
- en_rd_data, en_rd_S, en_rd_N  out  1 each  RAM read enables
- rd_addr_data_updated  out  BUF_AW  data-buffer read pointer
- rd_addr_S_vec  out  VEC_AW  S-RAM vector address
- rd_addr_S_coef  out  COEF_AW  S-RAM coefficient address
- rd_addr_N  out  VEC_AW  N-RAM address
- busy  out  1  high from leaving IDLE until DONE completes
- result_valid  out  1  one-cycle pulse per result
- result  out  ACC_W  evaluated value
- status  out  32  0 ok, 1 overflow, 2 undefined N, 3 N > MAX_DEG, 4 x_count = 0
- done_evp  out  1  one-cycle pulse at end of command

## Operation
- All RAMs are synchronous. An address and enable presented in cycle t give valid data in cycle t+1.
- Read enables are Moore decodes of the state. Addresses, result, status, result_valid and done_evp are registered.
- States:
  - IDLE: on start_evp, latch A, x_count and rd_addr_data, then go to RD_N.
  - RD_N: en_rd_N=1, rd_addr_N=A.
  - CHK_N: error checks in priority order 2, 3, 4. Any error goes to ERR; otherwise go to RD_X.
  - RD_X: en_rd_data=1; en_rd_S=1 at coef address N.
  - LOAD: x←ram_out_data; acc←ram_out_S. If N=0 go to EMIT, else set coef address to N−1 and go to FETCH.
  - FETCH: en_rd_S=1.
  - MAC: acc←acc·x + c_i. If address=0 go to EMIT, else decrement the address and go to FETCH.
  - EMIT: result←acc, status←ovf, result_valid←1. Increment the data pointer modulo BUF_DEPTH and decrement the remaining count. Go to RD_X if count≠0, else DONE.
  - ERR: result←0, status←code, result_valid←1, then DONE. No data or S reads are issued.
  - DONE: done_evp←1, then IDLE.
- Arithmetic: full product ACC_W+DATA_W+1 bits wide.
  - Any nonzero bit above ACC_W sets the per-sample ovf flag.
  - acc keeps the low ACC_W bits (wraps).
  - ovf clears in LOAD.
- start_evp while busy is ignored.
- Reset (asynchronous, any state) returns to IDLE:
  - all addresses 0, result 0, status 32'hFFFFFFFF;
  - busy, result_valid and done_evp 0;
  - no partial result is emitted.

## Timing
- start_evp sampled at edge k.
- First result_valid in cycle k+6+2N. Each further sample follows 3+2N cycles later.
- done_evp is asserted the cycle after the last result_valid.
- Error path: result_valid in cycle k+4, done_evp in cycle k+5.
- result and status hold their values until the next result_valid or reset.
- Data pointer wraps: start address BUF_DEPTH−1 is followed by address 0.

## Structure
- Shared package evp_pkg holds:
  - state encoding (localparam enum);
  - status codes;
  - the clog2 function.
- One sub-module, evp_horner_mac. It is combinational: inputs acc, x, c; outputs next_acc and ovf. This keeps the width rules in one place.

## Test plan
- A=2, N=2, c={3,2,1} (c0..c2), x=5, x_count=1 -> one result_valid with result=38, status=0, in cycle k+10; done_evp one cycle later.
- Same vector, x_count=3, x={0,1,2} -> results 3, 6, 11 spaced 7 cycles apart; rd_addr_data_updated advances by 3.
- N=5'b11111 -> result=0, status=2, en_rd_data never asserted; done_evp at k+5. Repeat with N=12 -> status=3. Repeat with x_count=0 -> status=4.
- ACC_W=32, N=3, x and all coefficients 16'hFFFF -> status=1 and result equal to the low 32 bits of the exact value.
- rd_addr_data=1023, x_count=2 -> data reads at 1023 then 0; pointer ends at 1.
- rst low during MAC of the second sample -> all outputs return to reset values immediately. A new start_evp then completes normally.
